mhd_error_monitor: RTL and testbench

Sequential error-metric engine for approximate-circuit evaluation. Streams N pairs of exact/approximate output vectors through a pipelined Hamming-distance unit. Accumulates the total distance, the maximum distance and the erroneous-sample count. Sits between the simulation/sample feeder and the error-report registers; supplies the MHD, mean-HD and error-rate numerators used for acceptance checks.

---
 rtl/mhd_pkg.sv | 17 +
 rtl/mhd_popcount.sv | 28 ++
 rtl/mhd_error_monitor.sv | 138 +++++++++++++
 tb/tb_mhd_error_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mhd_pkg.sv
// Shared definitions for the Hamming-distance error monitor.
//   state_t      : control FSM encoding (IDLE/RUN/DRAIN/DONE)
//   hd_width(w)  : bits needed to hold a distance between two w-bit vectors
package mhd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int hd_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational XOR + population count of two equal-width vectors.
//   a, b : vectors to compare (WIDTH bits)
//   hd   : number of differing bit positions (HD_W bits)
// Sized so that hd can represent WIDTH itself, valid for any WIDTH >= 1.
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [HD_W-1:0]  hd
);

  logic [WIDTH-1:0] diff;

  assign diff = a ^ b;

  // Written as a linear accumulation; synthesis rebalances it into a tree.
  always_comb begin
    hd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd = hd + HD_W'(diff[i]);
    end
  end

endmodule

// File: rtl/mhd_error_monitor.sv
// Streaming error-metric engine for approximate-circuit evaluation.
// Compares exact/approx vector pairs through a 2-stage Hamming-distance
// pipeline and accumulates total distance, maximum distance and the number
// of erroneous samples over a run of num_samples pairs.
//   clk, rst            : clock, async active-high reset
//   start, abort        : run control (abort wins over start)
//   num_samples         : pairs per run, latched on accepted start
//   in_valid, in_ready  : sample handshake, exact/approx : sample pair
//   busy, done          : run status
//   sample_cnt, err_cnt, max_hd, hd_sum : results
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | accepting pairs until sample_cnt reaches the latched count
// DRAIN | waiting for the last pair to leave the pipeline
// DONE  | results complete and stable
module mhd_error_monitor
  import mhd_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int CNT_W = 32,
  localparam int HD_W  = hd_width(WIDTH),
  localparam int SUM_W = CNT_W + HD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] exact,
  input  logic [WIDTH-1:0] approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [HD_W-1:0]  max_hd,
  output logic [SUM_W-1:0] hd_sum
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_q;
  logic [HD_W-1:0]  hd_now;
  logic [HD_W-1:0]  hd_q;
  logic             valid_q;
  logic             xfer;
  logic             start_ok;
  logic             last_xfer;

  mhd_popcount #(.WIDTH(WIDTH)) u_popcount (
    .a  (exact),
    .b  (approx),
    .hd (hd_now)
  );

  assign xfer      = in_valid & in_ready;
  assign last_xfer = xfer && ((sample_cnt + CNT_W'(1)) == count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    start_ok  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start && !abort) begin
          start_ok  = 1'b1;
          state_nxt = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Gated by abort combinationally so no pair slips in on the abort cycle.
        in_ready = (sample_cnt < count_q) && !abort;
        if (last_xfer) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!valid_q) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Run count latch and sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      sample_cnt <= '0;
    end else if (start_ok) begin
      count_q    <= num_samples;
      sample_cnt <= '0;
    end else if (xfer) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  // Stage 1: register the distance of the accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= xfer;
      if (xfer) hd_q <= hd_now;
    end
  end

  // Stage 2: fold into the result registers; abort discards the in-flight pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_sum  <= '0;
      max_hd  <= '0;
      err_cnt <= '0;
    end else if (start_ok) begin
      hd_sum  <= '0;
      max_hd  <= '0;
      err_cnt <= '0;
    end else if (valid_q && !abort) begin
      hd_sum <= hd_sum + SUM_W'(hd_q);
      if (hd_q > max_hd) max_hd <= hd_q;
      if (hd_q != '0) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mhd_error_monitor.sv
module tb_mhd_error_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] exact = '0;
  logic [63:0] approx = '0;
  logic        busy;
  logic        done;
  logic [31:0] sample_cnt;
  logic [31:0] err_cnt;
  logic [6:0]  max_hd;
  logic [38:0] hd_sum;

  int tests = 0;
  int fails = 0;
  int n;

  mhd_error_monitor #(.WIDTH(64), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .exact       (exact),
    .approx      (approx),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .max_hd      (max_hd),
    .hd_sum      (hd_sum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_start(input logic [31:0] cnt);
    start = 1'b1;
    num_samples = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sample_cnt"}, sample_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_max_hd"}, max_hd, 0);
    check({tag, "_hd_sum"}, hd_sum, 0);
  endtask

  initial begin
    logic [5:0] vld_pat;
    logic [63:0] pats [4];

    // Reset values
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("post_reset_in_ready", in_ready, 0);

    // Basic run: distances 0, 1, 64, 3
    pats[0] = 64'h0;
    pats[1] = 64'h1;
    pats[2] = '1;
    pats[3] = 64'h7;
    do_start(32'd4);
    check("basic_in_ready", in_ready, 1);
    check("basic_busy", busy, 1);
    exact = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      approx = pats[i];
      tick();
    end
    in_valid = 1'b0;
    check("basic_ready_drop", in_ready, 0);
    check("basic_busy_drain", busy, 1);
    wait_done(6, n);
    check("basic_done", done, 1);
    check("basic_latency_le3", (n <= 3), 1);
    check("basic_busy_done", busy, 0);
    check("basic_sample_cnt", sample_cnt, 4);
    check("basic_err_cnt", err_cnt, 3);
    check("basic_max_hd", max_hd, 64);
    check("basic_hd_sum", hd_sum, 68);

    // Restart from DONE: distances 5, 2
    do_start(32'd2);
    check("restart_cleared_sum", hd_sum, 0);
    check("restart_cleared_max", max_hd, 0);
    check("restart_cleared_cnt", sample_cnt, 0);
    in_valid = 1'b1;
    approx = 64'h1F;
    tick();
    approx = 64'h3;
    tick();
    in_valid = 1'b0;
    wait_done(6, n);
    check("restart_done", done, 1);
    check("restart_sample_cnt", sample_cnt, 2);
    check("restart_max_hd", max_hd, 5);
    check("restart_hd_sum", hd_sum, 7);
    check("restart_err_cnt", err_cnt, 2);

    // Backpressure: valid pattern 1,0,0,1,0,1 ; valid pairs have distance 8
    vld_pat = 6'b101001;
    do_start(32'd3);
    for (int i = 0; i < 6; i++) begin
      in_valid = vld_pat[i];
      approx = vld_pat[i] ? 64'hFF : '1;
      tick();
    end
    in_valid = 1'b1;
    approx = '1;
    check("bp_ready_after_3", in_ready, 0);
    check("bp_sample_cnt_3", sample_cnt, 3);
    wait_done(6, n);
    in_valid = 1'b0;
    check("bp_done", done, 1);
    check("bp_sample_cnt", sample_cnt, 3);
    check("bp_err_cnt", err_cnt, 3);
    check("bp_max_hd", max_hd, 8);
    check("bp_hd_sum", hd_sum, 24);

    // Zero samples
    do_start(32'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_in_ready", in_ready, 0);
    check("zero_sample_cnt", sample_cnt, 0);
    check("zero_err_cnt", err_cnt, 0);
    check("zero_max_hd", max_hd, 0);
    check("zero_hd_sum", hd_sum, 0);

    // Abort with sample 4 in stage 1: distances 1,2,3,4
    pats[0] = 64'h1;
    pats[1] = 64'h3;
    pats[2] = 64'h7;
    pats[3] = 64'hF;
    do_start(32'd10);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      approx = pats[i];
      tick();
    end
    approx = '1;
    abort = 1'b1;
    #1;
    check("abort_ready_gate", in_ready, 0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sample_cnt", sample_cnt, 4);
    check("abort_hd_sum", hd_sum, 6);
    check("abort_max_hd", max_hd, 3);
    check("abort_err_cnt", err_cnt, 3);
    tick();
    check("abort_hd_sum_hold", hd_sum, 6);

    // Abort and start together: abort wins, nothing cleared
    start = 1'b1;
    abort = 1'b1;
    num_samples = 32'd5;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_cnt", sample_cnt, 4);
    tick();
    check("abort_start_ready", in_ready, 0);

    // Reset mid-run after 5 transfers
    do_start(32'd10);
    in_valid = 1'b1;
    approx = 64'h1;
    repeat (5) tick();
    check("midrun_cnt_pre", sample_cnt, 5);
    rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    repeat (3) tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("midrun_post_ready", in_ready, 0);
    check("midrun_post_busy", busy, 0);

    // Monitor runs normally after reset
    do_start(32'd1);
    in_valid = 1'b1;
    approx = 64'h3;
    tick();
    in_valid = 1'b0;
    wait_done(6, n);
    check("post_rst_done", done, 1);
    check("post_rst_hd_sum", hd_sum, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
